// File: rtl/int_fu_pkg.sv
// Shared opcodes and state encoding for the integer FU execute stage.
// Imported by the ALU and the stage top.
package int_fu_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_ADD = 3'd0;
  localparam logic [OP_W-1:0] OP_SUB = 3'd1;
  localparam logic [OP_W-1:0] OP_AND = 3'd2;
  localparam logic [OP_W-1:0] OP_OR  = 3'd3;
  localparam logic [OP_W-1:0] OP_XOR = 3'd4;
  localparam logic [OP_W-1:0] OP_SLL = 3'd5;
  localparam logic [OP_W-1:0] OP_SRL = 3'd6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_WB   = 2'd2
  } state_t;

endpackage

// File: rtl/int_alu.sv
// Combinational integer ALU: add/sub wrap, bitwise logic,
// logical shifts by the low log2(WIDTH) bits of b.
module int_alu
  import int_fu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  localparam int SH_W = $clog2(WIDTH);

  logic [SH_W-1:0] sh;

  assign sh = b[SH_W-1:0];

  always_comb begin
    y = '0;
    unique case (op)
      OP_ADD:  y = a + b;
      OP_SUB:  y = a - b;
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_SLL:  y = a << sh;
      OP_SRL:  y = a >> sh;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/int_fu_exec_stage.sv
// Scoreboard-issued integer FU: latch op, spend EXEC_LAT cycles,
// then hold the result with wb_req until write-back is granted.
module int_fu_exec_stage
  import int_fu_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int TAG_W    = 4,
  parameter int EXEC_LAT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue_valid,
  output logic             issue_ready,
  input  logic [2:0]       issue_op,
  input  logic [TAG_W-1:0] issue_dst,
  input  logic [WIDTH-1:0] issue_a,
  input  logic [WIDTH-1:0] issue_b,
  output logic             wb_req,
  output logic [TAG_W-1:0] wb_dst,
  output logic [WIDTH-1:0] wb_data,
  input  logic             wb_grant,
  output logic             busy
);

  localparam int CNT_W = (EXEC_LAT > 1) ? $clog2(EXEC_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(EXEC_LAT - 1);

  state_t state, state_n;

  logic [CNT_W-1:0] cnt;
  logic [OP_W-1:0]  op_q;
  logic [TAG_W-1:0] dst_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] alu_y;
  logic             fire;
  logic             done;

  int_alu #(
    .WIDTH (WIDTH)
  ) u_alu (
    .op (op_q),
    .a  (a_q),
    .b  (b_q),
    .y  (alu_y)
  );

  assign fire = issue_valid & issue_ready;
  assign done = (state == ST_EXEC) && (cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n     = state;
    issue_ready = 1'b0;
    wb_req      = 1'b0;
    busy        = 1'b1;
    unique case (state)
      ST_IDLE: begin
        issue_ready = 1'b1;
        busy        = 1'b0;
        if (issue_valid) state_n = ST_EXEC;
      end
      ST_EXEC: begin
        if (cnt == '0) state_n = ST_WB;
      end
      ST_WB: begin
        wb_req = 1'b1;
        if (wb_grant) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      op_q    <= '0;
      dst_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      wb_dst  <= '0;
      wb_data <= '0;
    end else begin
      if (fire) begin
        cnt   <= CNT_INIT;
        op_q  <= issue_op;
        dst_q <= issue_dst;
        a_q   <= issue_a;
        b_q   <= issue_b;
      end
      if (state == ST_EXEC && cnt != '0) cnt <= cnt - 1'b1;
      // Result stays visible after the grant until the next op completes.
      if (done) begin
        wb_data <= alu_y;
        wb_dst  <= dst_q;
      end
    end
  end

endmodule

// File: tb/tb_int_fu_exec_stage.sv
// Directed + random bench for int_fu_exec_stage with an
// arithmetic reference model and handshake-timing checks.
module tb_int_fu_exec_stage;

  localparam int W = 16;
  localparam int T = 4;
  localparam int L = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         issue_valid;
  logic         issue_ready;
  logic [2:0]   issue_op;
  logic [T-1:0] issue_dst;
  logic [W-1:0] issue_a;
  logic [W-1:0] issue_b;
  logic         wb_req;
  logic [T-1:0] wb_dst;
  logic [W-1:0] wb_data;
  logic         wb_grant;
  logic         busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  int_fu_exec_stage #(
    .WIDTH    (W),
    .TAG_W    (T),
    .EXEC_LAT (L)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .issue_valid (issue_valid),
    .issue_ready (issue_ready),
    .issue_op    (issue_op),
    .issue_dst   (issue_dst),
    .issue_a     (issue_a),
    .issue_b     (issue_b),
    .wb_req      (wb_req),
    .wb_dst      (wb_dst),
    .wb_data     (wb_data),
    .wb_grant    (wb_grant),
    .busy        (busy)
  );

  function automatic logic [W-1:0] ref_alu(input int op,
                                           input int unsigned a,
                                           input int unsigned b);
    longint r;
    int unsigned sh;
    sh = b % W;
    case (op)
      0:       r = longint'(a) + longint'(b);
      1:       r = longint'(a) + 65536 - longint'(b);
      2:       r = longint'(a & b);
      3:       r = longint'(a | b);
      4:       r = longint'(a ^ b);
      5:       r = longint'(a) * (longint'(1) << sh);
      6:       r = longint'(a) / (longint'(1) << sh);
      default: r = 0;
    endcase
    return W'(r % 65536);
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input int op, input int dst,
                        input int unsigned a, input int unsigned b,
                        input int gd, input logic pulse);
    logic [W-1:0] exp;
    exp = ref_alu(op, a, b);
    chk("ready_idle", issue_ready, 1);
    issue_valid = 1'b1;
    issue_op    = 3'(op);
    issue_dst   = T'(dst);
    issue_a     = W'(a);
    issue_b     = W'(b);
    step;
    issue_valid = 1'b0;
    chk("busy_exec", busy, 1);
    chk("ready_exec", issue_ready, 0);
    chk("req_early", wb_req, 0);
    repeat (L - 1) begin
      step;
      chk("req_early", wb_req, 0);
    end
    step;
    chk("req_on", wb_req, 1);
    chk("wb_data", wb_data, exp);
    chk("wb_dst", wb_dst, dst);
    for (int i = 0; i < gd; i++) begin
      issue_valid = pulse;
      issue_op    = 3'($urandom_range(0, 7));
      issue_dst   = T'($urandom);
      issue_a     = W'($urandom);
      issue_b     = W'($urandom);
      step;
      chk("hold_req", wb_req, 1);
      chk("hold_data", wb_data, exp);
      chk("hold_dst", wb_dst, dst);
      chk("hold_ready", issue_ready, 0);
    end
    issue_valid = 1'b0;
    wb_grant    = 1'b1;
    step;
    wb_grant = 1'b0;
    chk("req_off", wb_req, 0);
    chk("busy_off", busy, 0);
    chk("ready_back", issue_ready, 1);
    chk("data_kept", wb_data, exp);
  endtask

  initial begin
    logic [W-1:0] exp_q[$];
    logic [T-1:0] dst_q[$];
    logic         fire;
    int           last_acc;

    rst         = 1'b1;
    issue_valid = 1'b1;
    issue_op    = 3'd0;
    issue_dst   = 4'd9;
    issue_a     = 16'd1;
    issue_b     = 16'd1;
    wb_grant    = 1'b1;
    step;
    step;
    chk("rst_ready", issue_ready, 1);
    chk("rst_req", wb_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_data", wb_data, 0);
    chk("rst_dst", wb_dst, 0);
    issue_valid = 1'b0;
    wb_grant    = 1'b0;
    rst         = 1'b0;
    step;
    chk("post_rst_busy", busy, 0);

    run_op(3, 1, 8, 6, 0, 1'b0);
    run_op(1, 2, 6, 8, 0, 1'b0);
    run_op(0, 3, 16'hFFFF, 1, 1, 1'b0);
    run_op(5, 4, 1, 16'h0013, 0, 1'b0);
    run_op(6, 6, 16'h8000, 15, 2, 1'b0);
    run_op(4, 5, 16'h1234, 16'h00FF, 3, 1'b1);
    run_op(7, 7, 16'hABCD, 16'h1111, 0, 1'b0);

    issue_valid = 1'b1;
    issue_op    = 3'd0;
    issue_dst   = 4'd8;
    issue_a     = 16'd100;
    issue_b     = 16'd200;
    step;
    issue_valid = 1'b0;
    chk("pre_rst_busy", busy, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_ready", issue_ready, 1);
    chk("mid_rst_req", wb_req, 0);
    chk("mid_rst_data", wb_data, 0);
    chk("mid_rst_busy", busy, 0);
    step;
    rst = 1'b0;
    repeat (L + 2) begin
      step;
      chk("dropped_req", wb_req, 0);
      chk("dropped_ready", issue_ready, 1);
    end
    run_op(3, 9, 3, 4, 0, 1'b0);

    for (int k = 0; k < 20; k++)
      run_op(int'($urandom_range(0, 7)), int'($urandom_range(0, 15)),
             $urandom_range(0, 65535), $urandom_range(0, 65535),
             int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));

    issue_valid = 1'b1;
    wb_grant    = 1'b1;
    issue_op    = 3'($urandom_range(0, 7));
    issue_dst   = T'($urandom);
    issue_a     = W'($urandom);
    issue_b     = W'($urandom);
    last_acc    = -1;
    for (int c = 0; c < 48 + L + 3; c++) begin
      if (c == 48) issue_valid = 1'b0;
      if (wb_req) begin
        if (exp_q.size() == 0) begin
          chk("b2b_spurious", 1, 0);
        end else begin
          chk("b2b_data", wb_data, exp_q.pop_front());
          chk("b2b_dst", wb_dst, dst_q.pop_front());
        end
      end
      fire = issue_valid & issue_ready;
      if (fire) begin
        exp_q.push_back(ref_alu(int'(issue_op), issue_a, issue_b));
        dst_q.push_back(issue_dst);
        if (last_acc >= 0) chk("b2b_gap", c - last_acc, L + 2);
        last_acc = c;
      end
      step;
      if (fire) begin
        issue_op  = 3'($urandom_range(0, 7));
        issue_dst = T'($urandom);
        issue_a   = W'($urandom);
        issue_b   = W'($urandom);
      end
    end
    wb_grant = 1'b0;
    chk("b2b_drain", exp_q.size(), 0);
    chk("b2b_idle", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
